occ_link_pattern_chk: RTL and testbench

Parametrised link test-pattern generator and checker for the OCC transceiver path. It sits between the user logic and the GTP/GTX tile (txdata/txcharisk, rxdata/rxcharisk/rxdisperr/rxnotintable) and is used for link bring-up and BER soak tests in hardware and simulation. The generator emits a K28.5 comma word every 2^g_COMMA_PERIOD_LOG2 words and a wrapping counter otherwise, for any byte width. The checker hunts for the comma, self-seeds from the stream, and counts mismatched words, coding errors and lock losses.

---
 rtl/occ_link_pattern_chk.sv | 181 ++++++++++++++++++
 tb/tb_occ_link_pattern_chk.sv | 272 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/occ_link_pattern_chk.sv
// Link test-pattern generator (K28.5 comma every 2^P words, counter otherwise)
// and self-seeding checker with error, word and lock-loss counters.
module occ_link_pattern_chk #(
  parameter int unsigned g_DATA_BYTES        = 2,
  parameter int unsigned g_COMMA_PERIOD_LOG2 = 5,
  parameter int unsigned g_UNLOCK_ERRS       = 4
) (
  input  logic                        clk_i,
  input  logic                        rst_n_i,
  input  logic                        tx_en_i,
  output logic [8*g_DATA_BYTES-1:0]   txdata_o,
  output logic [g_DATA_BYTES-1:0]     txcharisk_o,
  input  logic                        rx_valid_i,
  input  logic [8*g_DATA_BYTES-1:0]   rxdata_i,
  input  logic [g_DATA_BYTES-1:0]     rxcharisk_i,
  input  logic [g_DATA_BYTES-1:0]     rxdisperr_i,
  input  logic [g_DATA_BYTES-1:0]     rxnotintable_i,
  input  logic                        clr_i,
  output logic                        locked_o,
  output logic                        err_o,
  output logic [31:0]                 err_cnt_o,
  output logic [31:0]                 word_cnt_o,
  output logic [15:0]                 lockloss_cnt_o
);
  localparam int unsigned B = g_DATA_BYTES;
  localparam int unsigned W = 8 * g_DATA_BYTES;
  localparam int unsigned P = g_COMMA_PERIOD_LOG2;

  function automatic logic [W-1:0] comma_word();
    logic [W-1:0] w;
    for (int unsigned i = 0; i < B; i++) w[8*i +: 8] = (i == B - 1) ? 8'hBC : 8'h95;
    return w;
  endfunction

  function automatic logic [B-1:0] comma_k();
    logic [B-1:0] k;
    k        = '0;
    k[B-1]   = 1'b1;
    return k;
  endfunction

  localparam logic [W-1:0] C_WORD = comma_word();
  localparam logic [B-1:0] C_K    = comma_k();

  typedef enum logic [1:0] {ST_HUNT, ST_SEED, ST_LOCKED} state_e;

  logic [W-1:0]  gcnt_q, gcnt_d;
  logic [W-1:0]  txdata_q, txdata_d;
  logic [B-1:0]  txk_q, txk_d;
  state_e        state_q, state_d;
  logic [W-1:0]  exp_q, exp_d;
  logic [7:0]    consec_q, consec_d;
  logic          err_q, err_d;
  logic [31:0]   err_cnt_q, err_cnt_d;
  logic [31:0]   word_cnt_q, word_cnt_d;
  logic [15:0]   loss_cnt_q, loss_cnt_d;

  logic          err_inc, word_inc, loss_inc;
  logic          coderr, rx_is_comma, rx_seed_ok, rx_bad, exp_is_comma;
  logic [W-1:0]  exp_data;
  logic [B-1:0]  exp_k;

  always_comb begin
    gcnt_d   = gcnt_q;
    txdata_d = C_WORD;
    txk_d    = C_K;
    if (tx_en_i) begin
      if (gcnt_q[P-1:0] != '0) begin
        txdata_d = gcnt_q;
        txk_d    = '0;
      end
      gcnt_d = gcnt_q + W'(1);
    end
  end

  always_comb begin
    coderr       = (|rxdisperr_i) || (|rxnotintable_i);
    rx_is_comma  = (rxdata_i == C_WORD) && (rxcharisk_i == C_K) && !coderr;
    rx_seed_ok   = (rxcharisk_i == '0) && !coderr && (rxdata_i[P-1:0] == P'(1));
    exp_is_comma = (exp_q[P-1:0] == '0);
    exp_data     = exp_is_comma ? C_WORD : exp_q;
    exp_k        = exp_is_comma ? C_K : '0;
    rx_bad       = (rxdata_i != exp_data) || (rxcharisk_i != exp_k) || coderr;
  end

  always_comb begin
    state_d  = state_q;
    exp_d    = exp_q;
    consec_d = consec_q;
    err_d    = 1'b0;
    err_inc  = 1'b0;
    word_inc = 1'b0;
    loss_inc = 1'b0;
    case (state_q)
      ST_HUNT: if (rx_valid_i && rx_is_comma) state_d = ST_SEED;
      ST_SEED: begin
        if (!rx_valid_i)     state_d = ST_HUNT;
        else if (rx_is_comma) state_d = ST_SEED;
        else if (rx_seed_ok) begin
          exp_d   = rxdata_i + W'(1);
          state_d = ST_LOCKED;
        end else              state_d = ST_HUNT;
      end
      ST_LOCKED: begin
        if (!rx_valid_i) begin
          state_d  = ST_HUNT;
          loss_inc = 1'b1;
          consec_d = '0;
        end else begin
          word_inc = 1'b1;
          exp_d    = exp_q + W'(1);
          if (rx_bad) begin
            err_d   = 1'b1;
            err_inc = 1'b1;
            // consec_q counts earlier misses, so this word is the threshold-th one
            if (consec_q == 8'(g_UNLOCK_ERRS - 1)) begin
              state_d  = ST_HUNT;
              loss_inc = 1'b1;
              consec_d = '0;
            end else begin
              consec_d = consec_q + 8'd1;
            end
          end else begin
            consec_d = '0;
          end
        end
      end
      default: state_d = ST_HUNT;
    endcase
  end

  always_comb begin
    err_cnt_d  = err_cnt_q;
    word_cnt_d = word_cnt_q;
    loss_cnt_d = loss_cnt_q;
    if (clr_i) begin
      err_cnt_d  = '0;
      word_cnt_d = '0;
      loss_cnt_d = '0;
    end else begin
      if (err_inc  && (err_cnt_q  != '1)) err_cnt_d  = err_cnt_q  + 32'd1;
      if (word_inc && (word_cnt_q != '1)) word_cnt_d = word_cnt_q + 32'd1;
      if (loss_inc && (loss_cnt_q != '1)) loss_cnt_d = loss_cnt_q + 16'd1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      gcnt_q     <= '0;
      txdata_q   <= C_WORD;
      txk_q      <= C_K;
      state_q    <= ST_HUNT;
      exp_q      <= '0;
      consec_q   <= '0;
      err_q      <= 1'b0;
      err_cnt_q  <= '0;
      word_cnt_q <= '0;
      loss_cnt_q <= '0;
    end else begin
      gcnt_q     <= gcnt_d;
      txdata_q   <= txdata_d;
      txk_q      <= txk_d;
      state_q    <= state_d;
      exp_q      <= exp_d;
      consec_q   <= consec_d;
      err_q      <= err_d;
      err_cnt_q  <= err_cnt_d;
      word_cnt_q <= word_cnt_d;
      loss_cnt_q <= loss_cnt_d;
    end
  end

  assign txdata_o       = txdata_q;
  assign txcharisk_o    = txk_q;
  assign locked_o       = (state_q == ST_LOCKED);
  assign err_o          = err_q;
  assign err_cnt_o      = err_cnt_q;
  assign word_cnt_o     = word_cnt_q;
  assign lockloss_cnt_o = loss_cnt_q;

endmodule

// File: tb/tb_occ_link_pattern_chk.sv
// Scoreboard bench for occ_link_pattern_chk: B=2 main loopback with faults,
// plus free-running B=1 and B=4 loopbacks for wrap and width coverage.
module tb_occ_link_pattern_chk;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n, tx_en, clr, rxv2, rxv_aux, loop2, track;
  logic [15:0] flip2, rnd_data;
  logic [1:0]  rnd_k, rnd_disp, rnd_nit;
  logic        clr_aux;
  logic [0:0]  zero1;
  logic [3:0]  zero4;

  // B=2 DUT
  logic [15:0] txdata2, rxdata2;
  logic [1:0]  txk2, rxk2, disp2, nit2;
  logic        lk2, err2;
  logic [31:0] ec2, wc2;
  logic [15:0] lc2;
  // B=1 DUT
  logic [7:0]  txdata1;
  logic [0:0]  txk1;
  logic        lk1, err1;
  logic [31:0] ec1, wc1;
  logic [15:0] lc1;
  // B=4 DUT
  logic [31:0] txdata4;
  logic [3:0]  txk4;
  logic        lk4, err4;
  logic [31:0] ec4, wc4;
  logic [15:0] lc4;

  assign rxdata2 = loop2 ? (txdata2 ^ flip2) : rnd_data;
  assign rxk2    = loop2 ? txk2 : rnd_k;
  assign disp2   = loop2 ? 2'b00 : rnd_disp;
  assign nit2    = loop2 ? 2'b00 : rnd_nit;

  occ_link_pattern_chk #(.g_DATA_BYTES(2), .g_COMMA_PERIOD_LOG2(5), .g_UNLOCK_ERRS(4)) u_dut2 (
    .clk_i(clk), .rst_n_i(rst_n), .tx_en_i(tx_en), .txdata_o(txdata2), .txcharisk_o(txk2),
    .rx_valid_i(rxv2), .rxdata_i(rxdata2), .rxcharisk_i(rxk2), .rxdisperr_i(disp2),
    .rxnotintable_i(nit2), .clr_i(clr), .locked_o(lk2), .err_o(err2), .err_cnt_o(ec2),
    .word_cnt_o(wc2), .lockloss_cnt_o(lc2));

  occ_link_pattern_chk #(.g_DATA_BYTES(1), .g_COMMA_PERIOD_LOG2(5), .g_UNLOCK_ERRS(4)) u_dut1 (
    .clk_i(clk), .rst_n_i(rst_n), .tx_en_i(tx_en), .txdata_o(txdata1), .txcharisk_o(txk1),
    .rx_valid_i(rxv_aux), .rxdata_i(txdata1), .rxcharisk_i(txk1), .rxdisperr_i(zero1),
    .rxnotintable_i(zero1), .clr_i(clr_aux), .locked_o(lk1), .err_o(err1), .err_cnt_o(ec1),
    .word_cnt_o(wc1), .lockloss_cnt_o(lc1));

  occ_link_pattern_chk #(.g_DATA_BYTES(4), .g_COMMA_PERIOD_LOG2(5), .g_UNLOCK_ERRS(4)) u_dut4 (
    .clk_i(clk), .rst_n_i(rst_n), .tx_en_i(tx_en), .txdata_o(txdata4), .txcharisk_o(txk4),
    .rx_valid_i(rxv_aux), .rxdata_i(txdata4), .rxcharisk_i(txk4), .rxdisperr_i(zero4),
    .rxnotintable_i(zero4), .clr_i(clr_aux), .locked_o(lk4), .err_o(err4), .err_cnt_o(ec4),
    .word_cnt_o(wc4), .lockloss_cnt_o(lc4));

  int unsigned checks = 0;
  int unsigned errors = 0;

  logic [35:0] tx_q1[$], tx_q2[$], tx_q4[$];
  logic [31:0] err_q[$];
  logic [7:0]  m1;
  logic [15:0] m2;
  logic [31:0] m4;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=0x%0h required=0x%0h", name, act, req);
    end
  endtask

  // Expected generator output for one edge; comma constants written out by hand.
  function automatic logic [35:0] gen_exp(input logic [31:0] m, input int unsigned bytes,
                                          input logic en);
    logic [31:0] c;
    logic [3:0]  k;
    case (bytes)
      1:       begin c = 32'h0000_00BC; k = 4'b0001; end
      2:       begin c = 32'h0000_BC95; k = 4'b0010; end
      default: begin c = 32'hBC95_9595; k = 4'b1000; end
    endcase
    if (!en || (m[4:0] == 5'd0)) return {k, c};
    return {4'b0000, m};
  endfunction

  task automatic tick();
    @(posedge clk);
    if (track) begin
      tx_q1.push_back(gen_exp(32'(m1), 1, tx_en));
      tx_q2.push_back(gen_exp(32'(m2), 2, tx_en));
      tx_q4.push_back(gen_exp(m4, 4, tx_en));
      if (tx_en) begin
        m1 = m1 + 8'd1;
        m2 = m2 + 16'd1;
        m4 = m4 + 32'd1;
      end
    end
    #1;
  endtask

  task automatic monitor_loop();
    logic [35:0] e;
    forever begin
      @(negedge clk);
      if (tx_q1.size() > 0) begin
        e = tx_q1.pop_front();
        check("tx1_data", 32'(txdata1), e[31:0]);
        check("tx1_k", 32'(txk1), 32'(e[35:32]));
      end
      if (tx_q2.size() > 0) begin
        e = tx_q2.pop_front();
        check("tx2_data", 32'(txdata2), e[31:0]);
        check("tx2_k", 32'(txk2), 32'(e[35:32]));
      end
      if (tx_q4.size() > 0) begin
        e = tx_q4.pop_front();
        check("tx4_data", txdata4, e[31:0]);
        check("tx4_k", 32'(txk4), 32'(e[35:32]));
      end
      if (err2) begin
        if (err_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL err_unexpected actual=1 required=0 err_cnt=%0d", ec2);
        end else begin
          check("err_cnt_at_pulse", ec2, err_q.pop_front());
        end
      end
    end
  endtask

  task automatic wait_lock(input string name);
    int unsigned n = 0;
    while (!lk2 && n < 80) begin
      tick();
      n++;
    end
    check(name, 32'(lk2), 32'd1);
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, "_tx2"}, 32'(txdata2), 32'h0000_BC95);
    check({tag, "_txk2"}, 32'(txk2), 32'd2);
    check({tag, "_lock2"}, 32'(lk2), 32'd0);
    check({tag, "_err2"}, 32'(err2), 32'd0);
    check({tag, "_ec2"}, ec2, 32'd0);
    check({tag, "_wc2"}, wc2, 32'd0);
    check({tag, "_lc2"}, 32'(lc2), 32'd0);
    check({tag, "_tx1"}, 32'(txdata1), 32'h0000_00BC);
    check({tag, "_txk1"}, 32'(txk1), 32'd1);
    check({tag, "_tx4"}, txdata4, 32'hBC95_9595);
    check({tag, "_txk4"}, 32'(txk4), 32'd8);
  endtask

  initial begin
    rst_n = 1'b0; tx_en = 1'b0; clr = 1'b0; rxv2 = 1'b0; rxv_aux = 1'b0;
    loop2 = 1'b0; track = 1'b0; flip2 = '0; clr_aux = 1'b0; zero1 = '0; zero4 = '0;
    rnd_data = '0; rnd_k = '0; rnd_disp = '0; rnd_nit = '0;
    m1 = '0; m2 = '0; m4 = '0;
    fork
      monitor_loop();
    join_none

    // Reset held with random inputs
    for (int i = 0; i < 5; i++) begin
      rnd_data = 16'($urandom);
      rnd_k    = 2'($urandom);
      rnd_disp = 2'($urandom);
      rnd_nit  = 2'($urandom);
      tx_en    = 1'($urandom);
      clr      = 1'($urandom);
      rxv2     = 1'($urandom);
      rxv_aux  = 1'($urandom);
      tick();
      check_reset_vals("rst");
    end
    rst_n = 1'b1;
    #1;
    check_reset_vals("rel");

    tx_en = 1'b1; clr = 1'b0; rxv2 = 1'b1; rxv_aux = 1'b1; loop2 = 1'b1; track = 1'b1;
    // comma, comma, then 0x0001 seeds the checker
    tick();
    tick();
    check("lock_before_seed", 32'(lk2), 32'd0);
    tick();
    check("lock_after_seed", 32'(lk2), 32'd1);

    repeat (10000) tick();
    check("soak_lock", 32'(lk2), 32'd1);
    check("soak_err_cnt", ec2, 32'd0);
    check("soak_lockloss", 32'(lc2), 32'd0);
    check("soak_word_cnt", wc2, 32'd10000);

    // Single bit-3 error
    flip2 = 16'h0008;
    err_q.push_back(32'd1);
    tick();
    flip2 = '0;
    tick();
    check("single_lock", 32'(lk2), 32'd1);
    check("single_err_cnt", ec2, 32'd1);
    check("single_word_cnt", wc2, 32'd10002);

    // Clear wins over a same-cycle error
    clr = 1'b1;
    flip2 = 16'h0008;
    err_q.push_back(32'd0);
    tick();
    clr = 1'b0;
    flip2 = '0;
    check("clr_err_cnt", ec2, 32'd0);
    check("clr_word_cnt", wc2, 32'd0);
    repeat (5) tick();
    check("post_clr_word_cnt", wc2, 32'd5);
    check("post_clr_lock", 32'(lk2), 32'd1);

    // Four consecutive bad words drop lock
    for (int i = 0; i < 4; i++) begin
      flip2 = 16'h0008;
      err_q.push_back(32'(i + 1));
      tick();
    end
    flip2 = '0;
    check("unlock_err_cnt", ec2, 32'd4);
    check("unlock_lock", 32'(lk2), 32'd0);
    check("unlock_lockloss", 32'(lc2), 32'd1);
    wait_lock("relock");
    repeat (100) tick();
    check("relock_err_cnt", ec2, 32'd4);
    check("relock_lockloss", 32'(lc2), 32'd1);

    // rx_valid drop while locked
    clr = 1'b1;
    tick();
    clr = 1'b0;
    check("clr2_err_cnt", ec2, 32'd0);
    check("clr2_lockloss", 32'(lc2), 32'd0);
    rxv2 = 1'b0;
    tick();
    rxv2 = 1'b1;
    check("vdrop_lock", 32'(lk2), 32'd0);
    check("vdrop_lockloss", 32'(lc2), 32'd1);
    check("vdrop_err_cnt", ec2, 32'd0);
    wait_lock("vdrop_relock");

    // Width/wrap instances ran the whole time
    check("b1_lock", 32'(lk1), 32'd1);
    check("b1_err_cnt", ec1, 32'd0);
    check("b1_lockloss", 32'(lc1), 32'd0);
    check("b4_lock", 32'(lk4), 32'd1);
    check("b4_err_cnt", ec4, 32'd0);
    check("b4_lockloss", 32'(lc4), 32'd0);

    // tx_en low: commas only, counter held
    rxv2 = 1'b0;
    rxv_aux = 1'b0;
    tick();
    tx_en = 1'b0;
    repeat (3) tick();
    tx_en = 1'b1;
    repeat (3) tick();
    @(negedge clk);
    #1;
    check("err_pulses_pending", 32'(err_q.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
